gmii_tx_arbiter: RTL
====================

GMII_TX_ARBITER -- requirements
Module: gmii_tx_arbiter

Interface
REQ-001 Parameter IPG_BYTES, default 12, idle cycles between frames (range 1..255).
REQ-002 Parameter PREAMBLE_LEN, default 7, count of 0x55 bytes before SFD (range 1..15).
REQ-003 user_clk  input  1  byte clock feeding the RGMII transmitter (125M/12.5M/1.25M); sole clock.
REQ-004 reset  input  1  synchronous, active-high reset, sampled on rising user_clk.
REQ-005 in0_data  input  8  requester 0 frame byte (destination MAC onward, FCS included).
REQ-006 in0_valid  input  1  requester 0 byte valid.
REQ-007 in0_last  input  1  requester 0 final byte of frame.
REQ-008 in0_ready  output  1  requester 0 byte accepted when valid&ready.
REQ-009 in1_data / in1_valid / in1_last / in1_ready: same as REQ-005..008 for requester 1.
REQ-010 txd  output  8  GMII byte to transmitter.
REQ-011 txen  output  1  GMII transmit enable.
REQ-012 txer  output  1  GMII transmit error.
REQ-013 busy  output  1  high in any state other than IDLE.
REQ-014 underrun  output  1  one-cycle pulse when a granted frame starves.

Function
REQ-015 FSM states: IDLE, PREAMBLE, SFD, DATA, DRAIN, IPG.
REQ-016 txd/txen/txer SHALL be registered; the value loaded in a cycle in state X appears the following cycle.
REQ-017 IDLE: if any inN_valid, grant one requester, go to PREAMBLE next cycle; load txen=0, txer=0, txd=0.
REQ-018 Arbitration round-robin: with both valid, grant the requester not granted last; single valid requester always wins.
REQ-019 Grant SHALL be held unchanged from leaving IDLE until entering IPG.
REQ-020 PREAMBLE: load txd=0x55, txen=1 for exactly PREAMBLE_LEN cycles, then SFD.
REQ-021 SFD: load txd=0xD5, txen=1 for one cycle, then DATA.
REQ-022 inN_ready SHALL be combinational: high only for the granted requester in DATA or DRAIN; ungranted ready always 0.
REQ-023 DATA, granted valid=1: load txd=data, txen=1, txer=0; if last, go to IPG.
REQ-024 DATA, granted valid=0: load txd=0, txen=1, txer=1, pulse underrun, go to DRAIN.
REQ-025 DRAIN: load txen=0, txer=0; discard accepted bytes; on valid&last, go to IPG.
REQ-026 IPG: load txen=0 for exactly IPG_BYTES cycles, then IDLE.
REQ-027 Back-to-back frames SHALL therefore show txen low for exactly IPG_BYTES+1 cycles.
REQ-028 Preamble/IPG counter SHALL be 8 bits, loaded on state entry, decremented to zero; no wrap.
REQ-029 Valid changing on the ungranted port SHALL have no effect on the current frame.
REQ-030 Data arriving at the same edge IPG completes SHALL be arbitrated in the following IDLE cycle.

Reset
REQ-031 Reset SHALL force state IDLE, txd=0, txen=0, txer=0, busy=0, underrun=0, counter=0.
REQ-032 Reset SHALL set last-grant to requester 1 so requester 0 wins the first tie.
REQ-033 Reset asserted mid-frame SHALL abort immediately; txen low the cycle after reset is sampled; no byte accepted during reset.

Structure
REQ-034 State encoding, PREAMBLE_BYTE=0x55, SFD_BYTE=0xD5 SHALL live in shared package gmii_pkg.
REQ-035 Round-robin grant logic SHALL be one sub-module, rr_arb2 (two requests, grant, update strobe).
REQ-036 No clock crossing; outputs connect directly to the RGMII transmitter GMII inputs.

Verification
REQ-037 Single frame, in0 bytes 0x01..0x3C last on 0x3C -> txen 68 cycles: 7x0x55, 0xD5, 0x01..0x3C; txer never 1.
REQ-038 Both requesters valid from reset, 64-byte frames each -> order in0, in1, in0; txen gap 13 cycles each time.
REQ-039 in1 frame, valid drops after byte 10 -> 11th txen cycle of data has txer=1, txd=0; underrun pulses once; remaining bytes drained until last; then 12 IPG cycles.
REQ-040 Reset asserted during byte 20 of a frame -> txen=0 next cycle; in0_ready=0; next frame starts with full preamble.
REQ-041 IPG_BYTES=1, PREAMBLE_LEN=1, continuous in0 frames of 1 byte -> wire pattern 0x55, 0xD5, byte, two idle cycles, repeating.
REQ-042 in1 toggles valid while in0 frame active -> in1_ready stays 0; in0 frame bytes unchanged.

Source files
------------

// File: rtl/gmii_pkg.sv
// gmii_pkg: shared types and constants for the GMII transmit arbiter.
//   state_t    : arbiter FSM encoding
//   gmii_tx_t  : one registered GMII transmit beat (txd/txen/txer)
//   PREAMBLE_BYTE / SFD_BYTE : fixed wire bytes ahead of frame data
package gmii_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PREAMBLE,
    ST_SFD,
    ST_DATA,
    ST_DRAIN,
    ST_IPG
  } state_t;

  localparam logic [7:0] PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0] SFD_BYTE      = 8'hD5;

  typedef struct packed {
    logic [7:0] txd;
    logic       txen;
    logic       txer;
  } gmii_tx_t;

  localparam gmii_tx_t GMII_IDLE = '{txd: 8'h00, txen: 1'b0, txer: 1'b0};

endpackage

// File: rtl/gmii_tx_arbiter_rr_arb2.sv
// rr_arb2: two-way round-robin arbiter.
//   clk, reset : clock, synchronous active-high reset
//   req[1:0]   : request per requester
//   upd        : commit the current grant as "last granted"
//   gnt_vld    : at least one request present
//   gnt        : index of granted requester (combinational)
// After reset requester 1 counts as last granted, so requester 0 wins
// the first tie.
module rr_arb2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       upd,
  output logic       gnt_vld,
  output logic       gnt
);

  logic last_q, last_d;

  always_comb begin
    gnt_vld = |req;
    case (req)
      2'b01:   gnt = 1'b0;
      2'b10:   gnt = 1'b1;
      2'b11:   gnt = ~last_q;
      default: gnt = 1'b0;
    endcase
    last_d = last_q;
    if (upd && gnt_vld) last_d = gnt;
  end

  always_ff @(posedge clk) begin
    if (reset) last_q <= 1'b1;
    else       last_q <= last_d;
  end

endmodule

// File: rtl/gmii_tx_arbiter.sv
// gmii_tx_arbiter: merges two byte-stream frame sources onto one GMII
// transmit interface, inserting preamble, SFD and inter-packet gap.
//   user_clk, reset       : byte clock, synchronous active-high reset
//   inN_data/valid/last   : requester N frame bytes (DA..FCS)
//   inN_ready             : requester N byte accepted on valid&ready
//   txd/txen/txer         : registered GMII outputs
//   busy                  : FSM not idle
//   underrun              : one-cycle pulse when the granted source starves
module gmii_tx_arbiter
  import gmii_pkg::*;
#(
  parameter int IPG_BYTES    = 12,
  parameter int PREAMBLE_LEN = 7
) (
  input  logic       user_clk,
  input  logic       reset,
  input  logic [7:0] in0_data,
  input  logic       in0_valid,
  input  logic       in0_last,
  output logic       in0_ready,
  input  logic [7:0] in1_data,
  input  logic       in1_valid,
  input  logic       in1_last,
  output logic       in1_ready,
  output logic [7:0] txd,
  output logic       txen,
  output logic       txer,
  output logic       busy,
  output logic       underrun
);

  state_t   state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic     gnt_q, gnt_d;
  gmii_tx_t tx_q, tx_d;
  logic     underrun_q, underrun_d;

  logic       arb_vld, arb_gnt;
  logic       g_valid, g_last;
  logic [7:0] g_data;
  logic       rdy_st;

  rr_arb2 u_arb (
    .clk     (user_clk),
    .reset   (reset),
    .req     ({in1_valid, in0_valid}),
    .upd     (state_q == ST_IDLE),
    .gnt_vld (arb_vld),
    .gnt     (arb_gnt)
  );

  // Only the granted port is ever looked at once a frame is under way.
  assign g_valid = gnt_q ? in1_valid : in0_valid;
  assign g_last  = gnt_q ? in1_last  : in0_last;
  assign g_data  = gnt_q ? in1_data  : in0_data;

  // Gated by reset so nothing is consumed while the FSM is being cleared.
  assign rdy_st    = ((state_q == ST_DATA) || (state_q == ST_DRAIN)) && !reset;
  assign in0_ready = rdy_st && !gnt_q;
  assign in1_ready = rdy_st &&  gnt_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    gnt_d      = gnt_q;
    tx_d       = GMII_IDLE;
    underrun_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (arb_vld) begin
          gnt_d   = arb_gnt;
          cnt_d   = 8'(PREAMBLE_LEN);
          state_d = ST_PREAMBLE;
        end
      end
      ST_PREAMBLE: begin
        tx_d  = '{txd: PREAMBLE_BYTE, txen: 1'b1, txer: 1'b0};
        cnt_d = (cnt_q != 8'd0) ? cnt_q - 8'd1 : 8'd0;
        if (cnt_q <= 8'd1) state_d = ST_SFD;
      end
      ST_SFD: begin
        tx_d    = '{txd: SFD_BYTE, txen: 1'b1, txer: 1'b0};
        state_d = ST_DATA;
      end
      ST_DATA: begin
        if (g_valid) begin
          tx_d = '{txd: g_data, txen: 1'b1, txer: 1'b0};
          if (g_last) begin
            cnt_d   = 8'(IPG_BYTES);
            state_d = ST_IPG;
          end
        end else begin
          // Source starved mid-frame: corrupt the frame on the wire and
          // swallow the rest of it.
          tx_d       = '{txd: 8'h00, txen: 1'b1, txer: 1'b1};
          underrun_d = 1'b1;
          state_d    = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (g_valid && g_last) begin
          cnt_d   = 8'(IPG_BYTES);
          state_d = ST_IPG;
        end
      end
      ST_IPG: begin
        cnt_d = (cnt_q != 8'd0) ? cnt_q - 8'd1 : 8'd0;
        if (cnt_q <= 8'd1) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge user_clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 8'd0;
      gnt_q      <= 1'b0;
      tx_q       <= GMII_IDLE;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      gnt_q      <= gnt_d;
      tx_q       <= tx_d;
      underrun_q <= underrun_d;
    end
  end

  assign txd      = tx_q.txd;
  assign txen     = tx_q.txen;
  assign txer     = tx_q.txer;
  assign underrun = underrun_q;
  assign busy     = (state_q != ST_IDLE);

endmodule
